// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared definitions for the scanning N:1 registered multiplexer:
//   - state_e     : controller state encoding (IDLE / MANUAL / SCAN)
//   - MODE_*      : values of the mode input
//   - clog2()     : elaboration-time ceiling log2 used to size selects/counters
// -----------------------------------------------------------------------------
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3, clog2(8) = 3.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >>> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// -----------------------------------------------------------------------------
// mux_scan_next_ch
// Combinational channel finder for the scan sequencer.
//   ch_mask_i : per-channel enable mask
//   cur_i     : channel currently selected
//   next_o    : next enabled channel strictly above cur_i, else lowest enabled
//   wrapped_o : next_o was reached by wrapping past the top channel
//   lowest_o  : lowest enabled channel
//   any_set_o : at least one channel enabled
// With a single enabled channel equal to cur_i, next_o = cur_i and
// wrapped_o = 1, so that channel re-presents itself through a wrap.
// -----------------------------------------------------------------------------
module mux_scan_next_ch
    import mux_scan_pkg::*;
#(
    parameter  int NUM_CH = 8,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] ch_mask_i,
    input  logic [SEL_W-1:0]  cur_i,
    output logic [SEL_W-1:0]  next_o,
    output logic              wrapped_o,
    output logic [SEL_W-1:0]  lowest_o,
    output logic              any_set_o
);

    logic [SEL_W-1:0] above;
    logic             found_above;

    // Walking from the top down, the last hit wins, which leaves the lowest
    // enabled channel overall and the lowest enabled channel above cur_i.
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        lowest_o    = '0;
        above       = '0;
        found_above = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask_i[i]) begin
                lowest_o = SEL_W'(i);
                if (i > int'(cur_i)) begin
                    above       = SEL_W'(i);
                    found_above = 1'b1;
                end
            end
        end
    end

    assign any_set_o = |ch_mask_i;
    assign next_o    = found_above ? above : lowest_o;
    assign wrapped_o = any_set_o & ~found_above;

endmodule

// File: rtl/mux_scan_nto1.sv
// -----------------------------------------------------------------------------
// mux_scan_nto1
// N-channel, W-bit registered multiplexer with manual and self-scanning modes.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   en         : block enable; 0 forces IDLE (outputs held, dout_valid low)
//   mode       : 0 = MANUAL (sel_in picks channel), 1 = SCAN (auto-step)
//   sel_in     : channel select used in MANUAL
//   ch_mask    : per-channel scan enable
//   din        : flattened inputs, channel i = din[i*DATA_W +: DATA_W]
//   dout       : registered data of the channel in sel_out
//   sel_out    : channel driving dout (registered alongside dout)
//   dout_valid : dout/sel_out are meaningful
//   wrap       : one-cycle pulse when the scan returns to its lowest channel
// In SCAN each enabled channel is presented for DWELL consecutive cycles.
// -----------------------------------------------------------------------------
module mux_scan_nto1
    import mux_scan_pkg::*;
#(
    parameter  int NUM_CH = 8,
    parameter  int DATA_W = 1,
    parameter  int DWELL  = 4,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH*DATA_W-1:0] din,
    output logic [DATA_W-1:0]        dout,
    output logic [SEL_W-1:0]         sel_out,
    output logic                     dout_valid,
    output logic                     wrap
);

    localparam int               CNT_W    = (DWELL > 1) ? clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [SEL_W-1:0]  sel_q,   sel_d;
    logic [DATA_W-1:0] dout_q,  dout_d;
    logic              valid_q, valid_d;
    logic              wrap_q,  wrap_d;

    logic [SEL_W-1:0]  next_ch;
    logic [SEL_W-1:0]  lowest_ch;
    logic              next_wraps;
    logic              any_set;
    logic              sel_in_ok;
    logic              cur_enabled;

    mux_scan_next_ch #(
        .NUM_CH (NUM_CH)
    ) u_next_ch (
        .ch_mask_i (ch_mask),
        .cur_i     (sel_q),
        .next_o    (next_ch),
        .wrapped_o (next_wraps),
        .lowest_o  (lowest_ch),
        .any_set_o (any_set)
    );

    // sel_in can exceed NUM_CH-1 when NUM_CH is not a power of two.
    assign sel_in_ok = (int'(sel_in) < NUM_CH);

    // Mask bit of the channel being presented, looked up without indexing
    // past the mask.
    always_comb begin
        cur_enabled = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(sel_q) == i) begin
                cur_enabled = ch_mask[i];
            end
        end
    end

    // Next-state logic. Branch order encodes the priority:
    // disable > mode change > mask change > dwell expiry.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (mode == MODE_MANUAL) begin
            state_d = MANUAL;
            cnt_d   = '0;
            sel_d   = sel_in;
            valid_d = sel_in_ok;
            if (!sel_in_ok) begin
                dout_d = '0;
            end
        end else if (!any_set) begin
            // Scan requested with nothing enabled: park with dout/sel_out held.
            cnt_d = '0;
        end else if (state_q != SCAN || !valid_q) begin
            // Fresh entry, or resuming after a parked empty mask (the only way
            // SCAN sits with valid low): restart at the lowest channel.
            state_d = SCAN;
            sel_d   = lowest_ch;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b1;
            if (!cur_enabled || cnt_q == CNT_LAST) begin
                sel_d  = next_ch;
                wrap_d = next_wraps;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // dout is loaded from the same channel that sel_out takes this edge.
        if (valid_d) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(sel_d) == i) begin
                    dout_d = din[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign dout       = dout_q;
    assign sel_out    = sel_q;
    assign dout_valid = valid_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_nto1
// Two instances: A (8 ch x 8 bit, dwell 4) and B (5 ch x 4 bit, dwell 2, so
// sel_in can point past the last channel). Stimulus is applied on the falling
// edge; a reference model predicts the outputs after the next rising edge and
// queues them; a monitor compares them 1 ns after that rising edge.
// -----------------------------------------------------------------------------
module tb_mux_scan_nto1;

    localparam int A_N = 8, A_W = 8, A_DW = 4, A_SW = 3;
    localparam int B_N = 5, B_W = 4, B_DW = 2, B_SW = 3;

    typedef struct {
        logic [7:0] dout;
        int         sel;
        bit         valid;
        bit         wrap;
        bit         scanning;
        int         held;
    } mdl_t;

    typedef struct {
        logic [7:0] dout;
        int         sel;
        bit         valid;
        bit         wrap;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 a_en, a_mode;
    logic [A_SW-1:0]      a_sel_in;
    logic [A_N-1:0]       a_mask;
    logic [A_N*A_W-1:0]   a_din;
    logic [A_W-1:0]       a_dout;
    logic [A_SW-1:0]      a_sel_out;
    logic                 a_valid, a_wrap;

    logic                 b_en, b_mode;
    logic [B_SW-1:0]      b_sel_in;
    logic [B_N-1:0]       b_mask;
    logic [B_N*B_W-1:0]   b_din;
    logic [B_W-1:0]       b_dout;
    logic [B_SW-1:0]      b_sel_out;
    logic                 b_valid, b_wrap;

    mux_scan_nto1 #(.NUM_CH(A_N), .DATA_W(A_W), .DWELL(A_DW)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .mode(a_mode), .sel_in(a_sel_in),
        .ch_mask(a_mask), .din(a_din), .dout(a_dout), .sel_out(a_sel_out),
        .dout_valid(a_valid), .wrap(a_wrap)
    );

    mux_scan_nto1 #(.NUM_CH(B_N), .DATA_W(B_W), .DWELL(B_DW)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .mode(b_mode), .sel_in(b_sel_in),
        .ch_mask(b_mask), .din(b_din), .dout(b_dout), .sel_out(b_sel_out),
        .dout_valid(b_valid), .wrap(b_wrap)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    mdl_t ma, mb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference behaviour: one clock edge applied to the model state.
    // "held" counts how many cycles the current channel has been shown.
    function automatic mdl_t model_step(input mdl_t s, input int n, input int dwell,
                                        input bit en, input bit mode, input int sel_in,
                                        input logic [7:0] mask, input logic [7:0] data [8]);
        mdl_t r;
        bit   found;
        r      = s;
        r.wrap = 1'b0;
        if (!en) begin
            r.valid    = 1'b0;
            r.scanning = 1'b0;
        end else if (!mode) begin
            r.scanning = 1'b0;
            r.sel      = sel_in;
            if (sel_in < n) begin
                r.valid = 1'b1;
                r.dout  = data[sel_in];
            end else begin
                r.valid = 1'b0;
                r.dout  = '0;
            end
        end else if (mask == 8'h00) begin
            r.valid    = 1'b0;
            r.scanning = 1'b0;
        end else if (!s.scanning) begin
            found = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (!found && mask[i]) begin
                    r.sel = i;
                    found = 1'b1;
                end
            end
            r.held     = 1;
            r.scanning = 1'b1;
            r.valid    = 1'b1;
            r.dout     = data[r.sel];
        end else begin
            if (!mask[s.sel] || s.held >= dwell) begin
                found = 1'b0;
                for (int k = 1; k <= n; k++) begin
                    if (!found && mask[(s.sel + k) % n]) begin
                        r.sel  = (s.sel + k) % n;
                        r.wrap = (s.sel + k >= n);
                        found  = 1'b1;
                    end
                end
                r.held = 1;
            end else begin
                r.held = s.held + 1;
            end
            r.valid = 1'b1;
            r.dout  = data[r.sel];
        end
        return r;
    endfunction

    // Called on a falling edge with inputs already set: predict, queue,
    // then return on the next falling edge.
    task automatic step();
        logic [7:0] da [8];
        logic [7:0] db [8];
        exp_t       e;
        for (int i = 0; i < 8; i++) begin
            da[i] = '0;
            db[i] = '0;
        end
        for (int i = 0; i < A_N; i++) da[i] = a_din[i*A_W +: A_W];
        for (int i = 0; i < B_N; i++) db[i] = 8'(b_din[i*B_W +: B_W]);
        ma = model_step(ma, A_N, A_DW, a_en, a_mode, int'(a_sel_in), a_mask, da);
        mb = model_step(mb, B_N, B_DW, b_en, b_mode, int'(b_sel_in), 8'(b_mask), db);
        e = '{ma.dout, ma.sel, ma.valid, ma.wrap};
        q_a.push_back(e);
        e = '{mb.dout, mb.sel, mb.valid, mb.wrap};
        q_b.push_back(e);
        @(negedge clk);
    endtask

    task automatic rand_b();
        b_en     = ($urandom_range(0, 9) != 0);
        b_mode   = ($urandom_range(0, 2) != 0);
        b_sel_in = B_SW'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) b_mask = B_N'($urandom);
        b_din    = B_N*B_W'($urandom);
    endtask

    task automatic rand_a();
        int r;
        a_en     = ($urandom_range(0, 15) != 0);
        a_mode   = ($urandom_range(0, 3) != 0);
        a_sel_in = A_SW'($urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) begin
            r = $urandom_range(0, 7);
            if (r == 0)      a_mask = '0;
            else if (r == 1) a_mask = A_N'(1) << $urandom_range(0, A_N - 1);
            else             a_mask = A_N'($urandom);
        end
        a_din = {$urandom, $urandom};
    endtask

    task automatic reset_models();
        ma = '{default: 0};
        mb = '{default: 0};
    endtask

    // Monitor: compares every queued prediction against the DUT.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("a_dout",  a_dout,    e.dout);
                check("a_sel",   a_sel_out, e.sel);
                check("a_valid", a_valid,   e.valid);
                check("a_wrap",  a_wrap,    e.wrap);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b_dout",  b_dout,    e.dout);
                check("b_sel",   b_sel_out, e.sel);
                check("b_valid", b_valid,   e.valid);
                check("b_wrap",  b_wrap,    e.wrap);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        a_en = 0; a_mode = 0; a_sel_in = '0; a_mask = '0; a_din = '0;
        b_en = 0; b_mode = 0; b_sel_in = '0; b_mask = '0; b_din = '0;
        reset_models();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_dout",  a_dout,    0);
        check("rst_a_sel",   a_sel_out, 0);
        check("rst_a_valid", a_valid,   0);
        check("rst_a_wrap",  a_wrap,    0);
        check("rst_b_valid", b_valid,   0);
        rst_n = 1'b1;

        // Manual sweep on A with one-hot data; B exercises an out-of-range
        // select, a valid select, then disable.
        for (int i = 0; i < 8; i++) begin
            a_en = 1; a_mode = 0; a_sel_in = A_SW'(i);
            a_din = '0;
            a_din[i*A_W] = 1'b1;
            b_en = (i < 6); b_mode = 0;
            b_sel_in = (i < 3) ? 3'd6 : 3'd4;
            b_din = B_N*B_W'($urandom);
            step();
        end

        // Full-mask scan, channel i carries 8'hA0 + i.
        a_mode = 1; a_mask = 8'hFF;
        for (int i = 0; i < A_N; i++) a_din[i*A_W +: A_W] = 8'hA0 + 8'(i);
        for (int c = 0; c < 70; c++) begin
            rand_b();
            step();
        end

        // Sparse mask, then drop the bit of channel 4 just after arriving there.
        a_mask = 8'b1001_0100;
        for (int c = 0; c < 24; c++) begin
            rand_b();
            step();
        end
        reached = 0;
        for (int k = 0; k < 40 && !reached; k++) begin
            if (ma.scanning && ma.sel == 4 && ma.held == 1) reached = 1;
            else begin rand_b(); step(); end
        end
        check("reach_ch4", reached, 1);
        a_mask = 8'b1000_0100;
        for (int c = 0; c < 12; c++) begin
            rand_b();
            step();
        end

        // Empty mask parks the scan; a single channel then wraps every dwell.
        a_mask = '0;
        for (int c = 0; c < 20; c++) begin rand_b(); step(); end
        a_mask = 8'h08;
        for (int c = 0; c < 20; c++) begin rand_b(); step(); end

        // Asynchronous reset between edges while A presents channel 5.
        a_mask = 8'hFF;
        reached = 0;
        for (int k = 0; k < 60 && !reached; k++) begin
            if (ma.scanning && ma.sel == 5) reached = 1;
            else begin rand_b(); step(); end
        end
        check("reach_ch5", reached, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_a_dout",  a_dout,    0);
        check("arst_a_sel",   a_sel_out, 0);
        check("arst_a_valid", a_valid,   0);
        check("arst_a_wrap",  a_wrap,    0);
        check("arst_b_dout",  b_dout,    0);
        check("arst_b_sel",   b_sel_out, 0);
        check("arst_b_valid", b_valid,   0);
        reset_models();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin rand_b(); step(); end

        // Randomised traffic on both instances.
        for (int c = 0; c < 600; c++) begin
            rand_a();
            rand_b();
            step();
        end

        @(posedge clk);
        #3;
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
